reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 8 +
 rtl/reg_file.sv | 36 +++
 tb/tb_reg_file.sv | 138 +++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared geometry defaults for the scratch register file, so neighbouring
// datapath blocks can size their address/data buses to match.
package reg_file_pkg;

   localparam int RF_DATA_WIDTH = 8;
   localparam int RF_ADDR_WIDTH = 2;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Scratch/operand register file: one synchronous write port and one
// combinational read port. Rising-edge write; synchronous active-low clear.
module reg_file
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] entry_r [DEPTH];

   // Storage update: reset clears every entry and overrides any write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_r[i] <= '0;
         end
      end else if (wr_en) begin
         entry_r[w_addr] <= w_data;
      end
   end

   // No write-to-read bypass: a same-address write shows up after the edge.
   assign r_data = entry_r[r_addr];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random
// traffic, all compared against an array model of the register contents.
module tb_reg_file;

   logic       clk;
   logic       rst_n;
   logic       wr_en;
   logic [1:0] w_addr;
   logic [7:0] w_data;
   logic [1:0] r_addr;
   logic [7:0] r_data;

   logic [7:0] model [4];
   int total;
   int bad;

   reg_file dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .w_addr (w_addr),
      .w_data (w_data),
      .r_addr (r_addr),
      .r_data (r_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One rising edge; the model applies the same inputs the DUT sampled.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) model[i] = 8'h00;
      end else if (wr_en) begin
         model[w_addr] = w_data;
      end
      #1;
   endtask

   task automatic sweep(input string tag);
      for (int a = 0; a < 4; a++) begin
         r_addr = 2'(a);
         #1;
         check(tag, r_data, model[a]);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b1;
      wr_en = 1'b0;
      w_addr = 2'd0;
      w_data = 8'h00;
      r_addr = 2'd0;
      for (int i = 0; i < 4; i++) model[i] = 8'hxx;
      @(negedge clk);

      // Reset clears every entry.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sweep("reset");

      // Basic write to address 1.
      wr_en = 1'b1; w_addr = 2'd1; w_data = 8'b0000_1111;
      tick();
      wr_en = 1'b0;
      sweep("basic");
      r_addr = 2'd1; #1;
      check("basic_lit", r_data, 8'h0F);

      // Read-during-write at the same address: old value before, new after.
      wr_en = 1'b1; w_addr = 2'd1; w_data = 8'h5A; r_addr = 2'd1;
      #1;
      check("rdw_before", r_data, 8'h0F);
      tick();
      check("rdw_after", r_data, 8'h5A);
      wr_en = 1'b0;

      // Write disabled: entry 2 must stay zero.
      w_addr = 2'd2; w_data = 8'hAA;
      for (int k = 0; k < 3; k++) tick();
      r_addr = 2'd2; #1;
      check("wr_disabled", r_data, 8'h00);

      // Fill all entries on consecutive edges, then overwrite entry 3 only.
      wr_en = 1'b1;
      for (int a = 0; a < 4; a++) begin
         w_addr = 2'(a);
         w_data = 8'(8'h11 * (a + 1));
         tick();
      end
      wr_en = 1'b0;
      sweep("fill");
      wr_en = 1'b1; w_addr = 2'd3; w_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      sweep("overwrite3");

      // Reset wins over a simultaneous write.
      rst_n = 1'b0; wr_en = 1'b1; w_addr = 2'd0; w_data = 8'h77;
      tick();
      rst_n = 1'b1; wr_en = 1'b0;
      sweep("rst_priority");
      r_addr = 2'd0; #1;
      check("rst_priority_lit", r_data, 8'h00);

      // Random traffic with occasional resets.
      for (int n = 0; n < 300; n++) begin
         rst_n  = ($urandom_range(0, 19) != 0);
         wr_en  = 1'($urandom_range(0, 1));
         w_addr = 2'($urandom_range(0, 3));
         w_data = 8'($urandom);
         r_addr = 2'($urandom_range(0, 3));
         #1;
         check("rand_pre", r_data, model[r_addr]);
         tick();
         check("rand_post", r_data, model[r_addr]);
      end
      rst_n = 1'b1;
      wr_en = 1'b0;
      sweep("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_reg_file
